// File: rtl/wb_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_regfile: MEM/WB pipeline register fused with a 32x32 register file |
// | with two combinational read ports and WB-to-ID bypass.                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [4:0]        in_wr_addr,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [4:0]        wb_busy_addr,
  output logic [15:0]       commit_count
);

  localparam int ADDR_W = 5;

  logic              stg_valid;
  logic              stg_we;
  logic [ADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0] stg_data;

  logic [DATA_W-1:0] regs [NREGS];
  logic [15:0]       count;
  logic              commit;
  logic              stg_write;

  // A pending write only leaves the stage on an edge where the stage advances.
  assign stg_write = stg_valid && stg_we;
  assign commit    = !stall && stg_write && (stg_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_we    <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
    end else if (flush) begin
      stg_valid <= 1'b0;
      stg_we    <= 1'b0;
    end else if (!stall) begin
      stg_valid <= in_valid;
      stg_we    <= in_reg_write & in_valid;
      stg_addr  <= in_wr_addr;
      stg_data  <= in_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[stg_addr] <= stg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (commit) begin
      count <= count + 16'd1;
    end
  end

  // r0 reads as zero even if the stage holds a write aimed at it.
  always_comb begin
    rs_data = '0;
    if (rs_addr != '0) begin
      if (stg_write && (stg_addr == rs_addr)) begin
        rs_data = stg_data;
      end else begin
        rs_data = regs[rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != '0) begin
      if (stg_write && (stg_addr == rt_addr)) begin
        rt_data = stg_data;
      end else begin
        rt_data = regs[rt_addr];
      end
    end
  end

  assign wb_busy_addr = stg_write ? stg_addr : '0;
  assign commit_count = count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against a behavioural register-file model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_reg_write, stall, flush;
  logic [4:0]  in_wr_addr, rs_addr, rt_addr;
  logic [31:0] in_wr_data;
  wire  [31:0] rs_data, rt_data;
  wire  [4:0]  wb_busy_addr;
  wire  [15:0] commit_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: architectural registers plus one pending write.
  logic [31:0] m_regs [32];
  logic        m_valid, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_count;

  wb_regfile #(.DATA_W(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data), .stall(stall),
    .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .wb_busy_addr(wb_busy_addr), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_valid && m_we && m_addr == a) return m_data;
    return m_regs[a];
  endfunction

  function automatic logic [4:0] exp_busy();
    return (m_valid && m_we) ? m_addr : 5'd0;
  endfunction

  // One clock edge: the model consumes the same inputs the DUT sees.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      m_count = 16'd0;
    end else begin
      if (!stall && m_valid && m_we && m_addr != 5'd0) begin
        m_regs[m_addr] = m_data;
        m_count = m_count + 16'd1;
      end
      if (flush) begin
        m_valid = 1'b0; m_we = 1'b0;
      end else if (!stall) begin
        m_valid = in_valid; m_we = in_valid & in_reg_write;
        m_addr = in_wr_addr; m_data = in_wr_data;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] a,
                       input logic [31:0] d);
    in_valid = v; in_reg_write = we; in_wr_addr = a; in_wr_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    stall = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    drive(1'b1, 1'b1, 5'd4, 32'hAAAA5555);
    rst = 1'b1;
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a);
      #1;
      tests_run++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_read a=%0d rs=%h rt=%h want 0", a, rs_data, rt_data);
      end
    end
    tests_run++;
    if (commit_count !== 16'd0 || wb_busy_addr !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_state count=%0d busy=%0d want 0/0", commit_count, wb_busy_addr);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    rs_addr = 5'd5; rt_addr = 5'd6;
    #1;
    tests_run++;
    if (rs_data !== 32'hDEADBEEF || wb_busy_addr !== 5'd5 || commit_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL basic_bypass rs=%h busy=%0d count=%0d want deadbeef/5/0",
               rs_data, wb_busy_addr, commit_count);
    end
    tick();
    tests_run++;
    if (rs_data !== 32'hDEADBEEF || wb_busy_addr !== 5'd0 || commit_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL basic_array rs=%h busy=%0d count=%0d want deadbeef/0/1",
               rs_data, wb_busy_addr, commit_count);
    end
  endtask

  task automatic test_r0();
    logic [15:0] c0;
    c0 = commit_count;
    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    idle();
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    tests_run++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0 || wb_busy_addr !== 5'd0) begin
      tests_failed++;
      $display("FAIL r0_bypass rs=%h rt=%h busy=%0d want 0/0/0", rs_data, rt_data, wb_busy_addr);
    end
    tick();
    tests_run++;
    if (rs_data !== 32'd0 || commit_count !== c0) begin
      tests_failed++;
      $display("FAIL r0_commit rs=%h count=%0d want 0/%0d", rs_data, commit_count, c0);
    end
  endtask

  task automatic test_stall();
    logic [15:0] c0;
    c0 = commit_count;
    rt_addr = 5'd7; rs_addr = 5'd0;
    drive(1'b1, 1'b1, 5'd7, 32'h12);
    tick();
    drive(1'b1, 1'b1, 5'd7, 32'h34);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (rt_data !== 32'h12 || commit_count !== c0 || wb_busy_addr !== 5'd7) begin
        tests_failed++;
        $display("FAIL stall_hold cyc=%0d rt=%h count=%0d busy=%0d want 12/%0d/7",
                 i, rt_data, commit_count, wb_busy_addr, c0);
      end
    end
    stall = 1'b0;
    tick();
    idle();
    #1;
    tests_run++;
    if (rt_data !== 32'h34 || commit_count !== c0 + 16'd1) begin
      tests_failed++;
      $display("FAIL stall_release rt=%h count=%0d want 34/%0d", rt_data, commit_count, c0 + 16'd1);
    end
    tick();
    tests_run++;
    if (rt_data !== 32'h34 || commit_count !== c0 + 16'd2 || wb_busy_addr !== 5'd0) begin
      tests_failed++;
      $display("FAIL stall_drain rt=%h count=%0d busy=%0d want 34/%0d/0",
               rt_data, commit_count, wb_busy_addr, c0 + 16'd2);
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    drive(1'b1, 1'b1, 5'd9, 32'h77);
    tick();
    idle();
    tick();
    c0 = commit_count;
    rs_addr = 5'd9; rt_addr = 5'd10;
    drive(1'b1, 1'b1, 5'd9, 32'h55);
    flush = 1'b1; stall = 1'b1;
    tick();
    idle();
    #1;
    tests_run++;
    if (wb_busy_addr !== 5'd0 || rs_data !== 32'h77) begin
      tests_failed++;
      $display("FAIL flush_stall busy=%0d rs=%h want 0/77", wb_busy_addr, rs_data);
    end
    tick();
    tests_run++;
    if (rs_data !== 32'h77 || commit_count !== c0) begin
      tests_failed++;
      $display("FAIL flush_stall_after rs=%h count=%0d want 77/%0d", rs_data, commit_count, c0);
    end
    // Flush on the commit edge: pending write lands, incoming one is squashed.
    drive(1'b1, 1'b1, 5'd10, 32'h66);
    tick();
    drive(1'b1, 1'b1, 5'd10, 32'h99);
    flush = 1'b1;
    tick();
    idle();
    #1;
    tests_run++;
    if (rt_data !== 32'h66 || wb_busy_addr !== 5'd0 || commit_count !== c0 + 16'd1) begin
      tests_failed++;
      $display("FAIL flush_commit rt=%h busy=%0d count=%0d want 66/0/%0d",
               rt_data, wb_busy_addr, commit_count, c0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0;
    c0 = commit_count;
    rs_addr = 5'd3; rt_addr = 5'd3;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 5'd3, 32'(i));
      tick();
      tests_run++;
      if (rs_data !== 32'(i) || rt_data !== 32'(i)) begin
        tests_failed++;
        $display("FAIL b2b_bypass step=%0d rs=%h rt=%h want %h", i, rs_data, rt_data, 32'(i));
      end
    end
    idle();
    tick();
    tests_run++;
    if (rs_data !== 32'h3 || commit_count !== c0 + 16'd3) begin
      tests_failed++;
      $display("FAIL b2b_final rs=%h count=%0d want 3/%0d", rs_data, commit_count, c0 + 16'd3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
            $urandom);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
      rs_addr = ($urandom_range(0, 1) != 0) ? m_addr : 5'($urandom_range(0, 31));
      rt_addr = 5'($urandom_range(0, 31));
      #1;
      tests_run++;
      if (rs_data !== exp_read(rs_addr) || rt_data !== exp_read(rt_addr) ||
          wb_busy_addr !== exp_busy() || commit_count !== m_count) begin
        tests_failed++;
        $display("FAIL random i=%0d rs[%0d]=%h/%h rt[%0d]=%h/%h busy=%0d/%0d count=%0d/%0d",
                 i, rs_addr, rs_data, exp_read(rs_addr), rt_addr, rt_data,
                 exp_read(rt_addr), wb_busy_addr, exp_busy(), commit_count, m_count);
      end
    end
    idle();
  endtask

  task automatic test_wrap();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 1'b1, 5'd1, 32'(i));
      tick();
    end
    idle();
    rs_addr = 5'd1;
    #1;
    tests_run++;
    if (commit_count !== 16'hFFFF || rs_data !== 32'd65535) begin
      tests_failed++;
      $display("FAIL wrap_pre count=%h rs=%h want ffff/0000ffff", commit_count, rs_data);
    end
    tick();
    tests_run++;
    if (commit_count !== 16'h0000 || commit_count !== m_count || rs_data !== 32'd65535) begin
      tests_failed++;
      $display("FAIL wrap count=%h rs=%h want 0000/0000ffff", commit_count, rs_data);
    end
  endtask

  initial begin
    idle();
    rs_addr = 5'd0; rt_addr = 5'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_r0();
    test_stall();
    test_flush();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
